// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake with a two-entry
// skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         occupancy,
    output logic [COUNT_W-1:0] stall_count
);

    localparam logic [COUNT_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q,  main_d;
    logic [WIDTH-1:0]   skid_q,  skid_d;
    logic [COUNT_W-1:0] stall_q, stall_d;
    logic               in_fire;
    logic               out_fire;

    // Handshake flags decode registered state only, so ready never depends on out_ready.
    assign in_ready    = (state_q != ST_TWO);
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_data    = main_q;
    assign occupancy   = 2'(state_q);
    assign stall_count = stall_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        // Stall accounting is independent of flush.
        if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + COUNT_W'(1);
        end

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VALUE;
            skid_d  = RESET_VALUE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = RESET_VALUE;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = RESET_VALUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand-written
// corner sequences and a randomized scoreboard run.
module tb_pipe_stage_reg;

    localparam logic [15:0] RV = 16'hDEAD;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  occupancy;
    logic [2:0]  stall_count;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .WIDTH      (16),
        .RESET_VALUE(RV),
        .COUNT_W    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [15:0] od;
        logic [1:0]  occ;
        logic        ir;
        logic [2:0]  sc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [15:0] q[$];
    int unsigned sc_model;
    logic        ifire, ofire, stall_chk;
    logic [15:0] held;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_occ",       32'(occupancy), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'(RV));
        chk("rst_stall",     32'(stall_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // iv, d, ordy, fl | ov, od, occ, ir, sc
        vecs[0]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h1111, 2'd1, 1'b1, 3'd0};
        vecs[1]  = '{1'b1, 16'h2222, 1'b1, 1'b0, 1'b1, 16'h2222, 2'd1, 1'b1, 3'd0};
        vecs[2]  = '{1'b1, 16'h3333, 1'b1, 1'b0, 1'b1, 16'h3333, 2'd1, 1'b1, 3'd0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, RV,       2'd0, 1'b1, 3'd0};
        vecs[4]  = '{1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b1, 16'hAAAA, 2'd1, 1'b1, 3'd0};
        vecs[5]  = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1, 16'hAAAA, 2'd2, 1'b0, 3'd1};
        vecs[6]  = '{1'b1, 16'hDDDD, 1'b0, 1'b0, 1'b1, 16'hAAAA, 2'd2, 1'b0, 3'd2};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBBBB, 2'd1, 1'b1, 3'd2};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, RV,       2'd0, 1'b1, 3'd2};
        vecs[9]  = '{1'b1, 16'hEEEE, 1'b0, 1'b0, 1'b1, 16'hEEEE, 2'd1, 1'b1, 3'd2};
        vecs[10] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hEEEE, 2'd2, 1'b0, 3'd3};
        vecs[11] = '{1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0, RV,       2'd0, 1'b1, 3'd4};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, RV,       2'd0, 1'b1, 3'd4};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid),   32'(vecs[i].ov));
            chk($sformatf("vec%0d_out_data", i),  32'(out_data),    32'(vecs[i].od));
            chk($sformatf("vec%0d_occ", i),       32'(occupancy),   32'(vecs[i].occ));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),    32'(vecs[i].ir));
            chk($sformatf("vec%0d_stall", i),     32'(stall_count), 32'(vecs[i].sc));
        end

        // Stall counter saturation, then flush leaves it saturated
        do_reset();
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("sat_load_stall", 32'(stall_count), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0);
            chk($sformatf("sat_stall_%0d", i), 32'(stall_count), (i > 7) ? 32'd7 : 32'(i));
            chk($sformatf("sat_data_%0d", i),  32'(out_data), 32'h1234);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("sat_flush_stall", 32'(stall_count), 32'd7);
        chk("sat_flush_occ",   32'(occupancy),   32'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("sat_after_stall", 32'(stall_count), 32'd7);

        // Asynchronous reset while holding two words
        do_reset();
        step(1'b1, 16'hA1A1, 1'b0, 1'b0);
        step(1'b1, 16'hB2B2, 1'b0, 1'b0);
        chk("ar_pre_occ", 32'(occupancy), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid),   32'd0);
        chk("ar_occ",       32'(occupancy),   32'd0);
        chk("ar_stall",     32'(stall_count), 32'd0);
        chk("ar_out_data",  32'(out_data),    32'(RV));
        chk("ar_in_ready",  32'(in_ready),    32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 16'h5A5A, 1'b1, 1'b0);
        chk("ar_new_valid", 32'(out_valid), 32'd1);
        chk("ar_new_data",  32'(out_data),  32'h5A5A);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("ar_drain_valid", 32'(out_valid), 32'd0);
        chk("ar_drain_data",  32'(out_data),  32'(RV));

        // Randomized traffic against a queue scoreboard
        do_reset();
        #1;
        sc_model = 0;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            ifire     = in_valid & in_ready;
            ofire     = out_valid & out_ready;
            if (ofire) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_spurious: got %h expected nothing at %0t", out_data, $time);
                end else begin
                    chk("rnd_data", 32'(out_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (out_valid && !out_ready && sc_model < 7) sc_model++;
            stall_chk = out_valid & ~out_ready & ~flush;
            held      = out_data;
            if (flush) q.delete();
            else if (ifire) q.push_back(in_data);
            @(posedge clk);
            #1;
            chk("rnd_occ",       32'(occupancy),   32'(q.size()));
            chk("rnd_out_valid", 32'(out_valid),   32'(q.size() != 0));
            chk("rnd_in_ready",  32'(in_ready),    32'(q.size() < 2));
            chk("rnd_stall",     32'(stall_count), 32'(sc_model));
            if (stall_chk) chk("rnd_stable", 32'(out_data), 32'(held));
            if (q.size() == 0) chk("rnd_empty_data", 32'(out_data), 32'(RV));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
